// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: csr_def types used by the trap sequencer (modes, mstatus/tvec layouts, trap kinds, IRQ priority).
package trap_ctrl_pkg;
    typedef enum logic [1:0] {MODE_U = 2'd0, MODE_S = 2'd1, MODE_RSV = 2'd2, MODE_M = 2'd3} cpu_mode_t;
    typedef enum logic [1:0] {KIND_NONE = 2'd0, KIND_EXC = 2'd1, KIND_MRET = 2'd2, KIND_SRET = 2'd3} trap_kind_t;
    typedef enum logic [2:0] {ST_BOOT, ST_IDLE, ST_DRAIN, ST_WRITE, ST_REDIRECT} trap_state_t;
    typedef logic [31:0] mip_t;
    typedef logic [31:0] mie_t;
    typedef struct packed {
        logic       sd;
        logic [7:0] wpri23;
        logic       tsr, tw, tvm, mxr, sum, mprv;
        logic [1:0] xs, fs;
        cpu_mode_t  mpp;
        logic [1:0] vs;
        logic       spp, mpie, ube, spie, wpri4, mie, wpri2, sie, wpri0;
    } mstatus_t;
    typedef struct packed {
        logic [29:0] base;
        logic [1:0]  mode;
    } tvec_t;
    localparam logic [4:0] IRQ_MEI = 5'd11;
    localparam logic [4:0] IRQ_MSI = 5'd3;
    localparam logic [4:0] IRQ_MTI = 5'd7;
    localparam logic [4:0] IRQ_SEI = 5'd9;
    localparam logic [4:0] IRQ_SSI = 5'd1;
    localparam logic [4:0] IRQ_STI = 5'd5;
    localparam int IRQ_N = 6;
    localparam logic [4:0] IRQ_PRIO [IRQ_N] = '{IRQ_MEI, IRQ_MSI, IRQ_MTI, IRQ_SEI, IRQ_SSI, IRQ_STI};
endpackage

// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: commit-event, CSR, pipeline-drain and fetch-redirect signals around the trap sequencer.
interface trap_ctrl_if;
    import trap_ctrl_pkg::*;
    logic        evt_valid, evt_ready;
    trap_kind_t  evt_kind;
    logic [4:0]  evt_cause;
    logic [31:0] evt_pc, evt_tval;
    mip_t        mip;
    mie_t        mie;
    mstatus_t    mstatus;
    logic [31:0] mideleg, medeleg;
    tvec_t       mtvec, stvec;
    logic [31:0] mepc, sepc;
    logic        flush_req, flush_ack;
    logic        csr_we, csr_to_s, csr_cause_we;
    mstatus_t    wb_mstatus;
    logic [31:0] wb_cause, wb_epc, wb_tval;
    logic        redirect_valid, redirect_ready;
    logic [31:0] redirect_pc;
    cpu_mode_t   priv_mode;
    modport master (
        output evt_valid, evt_kind, evt_cause, evt_pc, evt_tval, mip, mie, mstatus,
               mideleg, medeleg, mtvec, stvec, mepc, sepc, flush_ack, redirect_ready,
        input  evt_ready, flush_req, csr_we, csr_to_s, csr_cause_we, wb_mstatus,
               wb_cause, wb_epc, wb_tval, redirect_valid, redirect_pc, priv_mode
    );
    modport slave (
        input  evt_valid, evt_kind, evt_cause, evt_pc, evt_tval, mip, mie, mstatus,
               mideleg, medeleg, mtvec, stvec, mepc, sepc, flush_ack, redirect_ready,
        output evt_ready, flush_req, csr_we, csr_to_s, csr_cause_we, wb_mstatus,
               wb_cause, wb_epc, wb_tval, redirect_valid, redirect_pc, priv_mode
    );
endinterface

// File: rtl/trap_ctrl_irq_arbiter.sv
// trap_irq_arbiter: gates pending interrupts by mode/enables and picks the highest-priority one.
module trap_irq_arbiter
    import trap_ctrl_pkg::*;
(
    input  logic [31:0] mip,
    input  logic [31:0] mie,
    input  logic [31:0] mideleg,
    input  logic        status_mie,
    input  logic        status_sie,
    input  cpu_mode_t   mode,
    output logic        take,
    output logic [4:0]  code,
    output logic        to_s
);
    logic [31:0] en;
    logic m_en, s_en;
    assign m_en = mode != MODE_M || status_mie;
    assign s_en = mode == MODE_U || (mode == MODE_S && status_sie);
    assign en = mip & mie & ((mideleg & {32{s_en}}) | (~mideleg & {32{m_en}}));
    // Scan lowest priority first so the highest-priority hit is written last.
    always_comb begin
        take = 1'b0;
        code = '0;
        for (int i = IRQ_N - 1; i >= 0; i--)
            if (en[IRQ_PRIO[i]]) begin
                take = 1'b1;
                code = IRQ_PRIO[i];
            end
    end
    assign to_s = take && mode != MODE_M && mideleg[code];
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: privilege/trap sequencer; arbitrates commit events vs interrupts, drains, writes CSRs, redirects fetch.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter bit          VEC_EN   = 1'b1
) (
    input logic        clk,
    input logic        rst,
    trap_ctrl_if.slave bus
);
    trap_state_t state, state_n;
    cpu_mode_t   priv, new_mode;
    trap_kind_t  kind;
    mstatus_t    ms_n;
    tvec_t       tvec;
    logic        irq_take, irq_to_s, is_int, to_s, trap, act, accept;
    logic [4:0]  irq_code, code;
    logic [31:0] epc, tval, target, rpc;
    trap_irq_arbiter u_arb (
        .mip(bus.mip), .mie(bus.mie), .mideleg(bus.mideleg),
        .status_mie(bus.mstatus.mie), .status_sie(bus.mstatus.sie),
        .mode(priv), .take(irq_take), .code(irq_code), .to_s(irq_to_s)
    );
    assign act    = irq_take || bus.evt_kind != KIND_NONE;
    assign accept = state == ST_IDLE && bus.evt_valid && act;
    assign trap   = is_int || kind == KIND_EXC;
    always_comb begin
        state_n = state;
        case (state)
            ST_BOOT:     state_n = bus.redirect_ready ? ST_IDLE : ST_BOOT;
            ST_IDLE:     state_n = (bus.evt_valid && act) ? ST_DRAIN : ST_IDLE;
            ST_DRAIN:    state_n = bus.flush_ack ? ST_WRITE : ST_DRAIN;
            ST_WRITE:    state_n = ST_REDIRECT;
            ST_REDIRECT: state_n = bus.redirect_ready ? ST_IDLE : ST_REDIRECT;
            default:     state_n = ST_BOOT;
        endcase
    end
    always_comb begin
        ms_n     = bus.mstatus;
        new_mode = priv;
        tvec     = to_s ? bus.stvec : bus.mtvec;
        target   = {tvec.base, 2'b00} + ((VEC_EN && is_int && tvec.mode == 2'b01) ? {25'b0, code, 2'b00} : 32'b0);
        if (trap && !to_s) begin
            ms_n.mpie = bus.mstatus.mie;
            ms_n.mie  = 1'b0;
            ms_n.mpp  = priv;
            new_mode  = MODE_M;
        end else if (trap) begin
            ms_n.spie = bus.mstatus.sie;
            ms_n.sie  = 1'b0;
            ms_n.spp  = priv[0];
            new_mode  = MODE_S;
        end else if (kind == KIND_MRET) begin
            ms_n.mie  = bus.mstatus.mpie;
            ms_n.mpie = 1'b1;
            ms_n.mpp  = MODE_U;
            new_mode  = bus.mstatus.mpp;
            target    = bus.mepc;
        end else begin
            ms_n.sie  = bus.mstatus.spie;
            ms_n.spie = 1'b1;
            ms_n.spp  = 1'b0;
            new_mode  = bus.mstatus.spp ? MODE_S : MODE_U;
            target    = bus.sepc;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_BOOT;
            priv   <= MODE_M;
            rpc    <= RESET_PC & 32'hFFFF_FFFC;
            kind   <= KIND_NONE;
            is_int <= 1'b0;
            code   <= '0;
            to_s   <= 1'b0;
            epc    <= '0;
            tval   <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                kind   <= bus.evt_kind;
                is_int <= irq_take;
                code   <= irq_take ? irq_code : bus.evt_cause;
                to_s   <= irq_take ? irq_to_s
                        : (bus.evt_kind == KIND_EXC && priv != MODE_M && bus.medeleg[bus.evt_cause]);
                epc    <= bus.evt_pc;
                tval   <= irq_take ? 32'b0 : bus.evt_tval;
            end
            if (state == ST_WRITE) begin
                priv <= new_mode;
                rpc  <= target & 32'hFFFF_FFFC;
            end
        end
    end
    // Outputs are masked during reset so an in-flight write-back is dropped at once.
    assign bus.evt_ready      = !rst && state == ST_IDLE;
    assign bus.flush_req      = !rst && state == ST_DRAIN;
    assign bus.csr_we         = !rst && state == ST_WRITE;
    assign bus.csr_cause_we   = bus.csr_we && trap;
    assign bus.csr_to_s       = to_s;
    assign bus.wb_mstatus     = bus.csr_we ? ms_n : '0;
    assign bus.wb_cause       = {is_int, 26'b0, code};
    assign bus.wb_epc         = epc;
    assign bus.wb_tval        = tval;
    assign bus.redirect_valid = !rst && (state == ST_BOOT || state == ST_REDIRECT);
    assign bus.redirect_pc    = rpc;
    assign bus.priv_mode      = priv;
endmodule
